// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle between NUM_SRC single-beat sources, the arbiter and one consumer.
// Signal names carry the arbiter's own direction suffixes.
interface axis_rr_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]            s_axis_tvalid_i;
    logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata_i;
    logic [NUM_SRC-1:0]            s_axis_tready_o;
    logic                          m_axis_tready_i;
    logic                          m_axis_tvalid_o;
    logic [DATA_WIDTH-1:0]         m_axis_tdata_o;
    logic [SRC_W-1:0]              m_axis_tid_o;

    // Arbiter side: consumes the source beats, produces the merged stream.
    modport slave (
        input  s_axis_tvalid_i, s_axis_tdata_i, m_axis_tready_i,
        output s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tid_o
    );

    // Environment side: the sources and the downstream consumer.
    modport master (
        output s_axis_tvalid_i, s_axis_tdata_i, m_axis_tready_i,
        input  s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tid_o
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of NUM_SRC single-beat AXI-stream sources into one registered
// output stream, each beat tagged with the index of the source that produced it.
module axis_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   axis_aclk_i,
    input  logic                   axis_aresetn_i,
    axis_rr_arbiter_if.slave       bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01
    } state_t;

    state_t                r_state;
    logic [SRC_W-1:0]      r_ptr;
    logic [SRC_W-1:0]      r_tid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;

    logic [SRC_W-1:0]      w_sel;
    logic                  w_any;
    logic                  w_slot;
    logic                  w_accept;
    logic [NUM_SRC-1:0]    w_tready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SRC_W-1:0]      w_idx;

    // Search upward from the slot after the last accepted source, wrapping.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = SRC_W'((int'(r_ptr) + k) % NUM_SRC);
            if (!w_any && bus.s_axis_tvalid_i[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    // Illegal state encodings behave as idle; reset also forces every tready low.
    assign w_slot   = (r_state != ST_SEND) || bus.m_axis_tready_i;
    assign w_accept = axis_aresetn_i && w_any && w_slot;
    assign w_data   = bus.s_axis_tdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_tready = '0;
        if (w_accept) begin
            w_tready[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            r_state  <= ST_IDLE;
            r_ptr    <= SRC_W'(NUM_SRC - 1);
            r_tid    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_SEND: begin
                    if (bus.m_axis_tready_i) begin
                        if (w_accept) begin
                            r_tdata  <= w_data;
                            r_tid    <= w_sel;
                            r_ptr    <= w_sel;
                            r_tvalid <= 1'b1;
                        end else begin
                            r_tvalid <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_tdata  <= w_data;
                        r_tid    <= w_sel;
                        r_ptr    <= w_sel;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_SEND;
                    end else begin
                        r_tvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.s_axis_tready_o = w_tready;
    assign bus.m_axis_tvalid_o = r_tvalid;
    assign bus.m_axis_tdata_o  = r_tdata;
    assign bus.m_axis_tid_o    = r_tid;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed and random checks of axis_rr_arbiter: reset, single source, rotation,
// backpressure, pointer wrap, and a scoreboard-checked random run.
module tb_axis_rr_arbiter;
    localparam int NUM_SRC    = 4;
    localparam int DATA_WIDTH = 8;

    typedef struct {
        logic [1:0] tid;
        logic [7:0] data;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    beat_t      sb[$];
    logic [3:0] hs_last = '0;
    int         wait_cnt[NUM_SRC];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_tid;

    axis_rr_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH)) bus ();

    axis_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH)) dut (
        .axis_aclk_i    (clk),
        .axis_aresetn_i (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [7:0] d);
        bus.s_axis_tvalid_i[i] = v;
        bus.s_axis_tdata_i[i*8 +: 8] = d;
    endtask

    // Monitor: values seen at the falling edge are the ones the next rising edge uses.
    always @(negedge clk) begin
        logic [3:0] hs;
        logic       out_hs;
        beat_t      b;
        if (!rst_n) begin
            prev_stall = 1'b0;
            hs_last    = '0;
            for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] = 0;
        end else begin
            hs     = bus.s_axis_tready_o & bus.s_axis_tvalid_i;
            out_hs = bus.m_axis_tvalid_o & bus.m_axis_tready_i;
            chk("tready_onehot0", 32'($onehot0(bus.s_axis_tready_o)), 32'd1);
            chk("tready_to_idle_src", 32'(bus.s_axis_tready_o & ~bus.s_axis_tvalid_i), 32'd0);
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.m_axis_tvalid_o), 32'd1);
                chk("stall_data", 32'(bus.m_axis_tdata_o), 32'(prev_data));
                chk("stall_tid", 32'(bus.m_axis_tid_o), 32'(prev_tid));
            end
            prev_stall = bus.m_axis_tvalid_o & ~bus.m_axis_tready_i;
            prev_data  = bus.m_axis_tdata_o;
            prev_tid   = bus.m_axis_tid_o;
            if (out_hs) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    b = sb.pop_front();
                    chk("sb_tid", 32'(bus.m_axis_tid_o), 32'(b.tid));
                    chk("sb_data", 32'(bus.m_axis_tdata_o), 32'(b.data));
                end
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hs[i]) begin
                    b.tid  = 2'(i);
                    b.data = bus.s_axis_tdata_i[i*8 +: 8];
                    sb.push_back(b);
                    wait_cnt[i] = 0;
                end else if (!bus.s_axis_tvalid_i[i]) begin
                    wait_cnt[i] = 0;
                end else if (hs != 4'b0) begin
                    wait_cnt[i]++;
                    chk($sformatf("starve_src%0d", i), 32'(wait_cnt[i] <= NUM_SRC - 1), 32'd1);
                end
            end
            hs_last = hs;
        end
    end

    initial begin
        logic [3:0] vld;
        logic [5:0] seq[NUM_SRC];
        int         budget;

        rst_n = 1'b0;
        bus.s_axis_tvalid_i = '0;
        bus.s_axis_tdata_i  = '0;
        bus.m_axis_tready_i = 1'b0;

        // Power-up reset values, with requests present.
        repeat (2) step();
        bus.s_axis_tvalid_i = 4'hF;
        #1;
        chk("rst_tvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
        chk("rst_tdata", 32'(bus.m_axis_tdata_o), 32'd0);
        chk("rst_tid", 32'(bus.m_axis_tid_o), 32'd0);
        chk("rst_tready", 32'(bus.s_axis_tready_o), 32'd0);
        bus.s_axis_tvalid_i = '0;
        step();
        rst_n = 1'b1;

        // Reset while a beat is pending downstream.
        step();
        set_src(0, 1'b1, 8'h5A);
        step();
        set_src(0, 1'b0, 8'h00);
        #1;
        chk("send_before_rst", 32'(bus.m_axis_tvalid_o), 32'd1);
        step();
        bus.s_axis_tvalid_i = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
        chk("midrst_tready", 32'(bus.s_axis_tready_o), 32'd0);
        bus.s_axis_tvalid_i = '0;
        step();
        sb.delete();
        rst_n = 1'b1;

        // Round-robin with all sources valid; first grant shows the pointer was reset.
        step();
        bus.m_axis_tready_i = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, 8'(8'h10 + i));
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_tready", 32'(bus.s_axis_tready_o), 32'(1 << (k % 4)));
            step();
            if (k == 7) bus.s_axis_tvalid_i = '0;
            #1;
            chk("rr_tvalid", 32'(bus.m_axis_tvalid_o), 32'd1);
            chk("rr_tid", 32'(bus.m_axis_tid_o), 32'(k % 4));
            chk("rr_tdata", 32'(bus.m_axis_tdata_o), 32'(8'h10 + (k % 4)));
        end
        step();
        #1;
        chk("rr_drain", 32'(bus.m_axis_tvalid_o), 32'd0);

        // Pointer wrap: last grant was source 3, so source 0 beats source 3.
        set_src(0, 1'b1, 8'hC0);
        set_src(3, 1'b1, 8'hC3);
        #1;
        chk("wrap_first", 32'(bus.s_axis_tready_o), 32'b0001);
        step();
        set_src(0, 1'b0, 8'h00);
        #1;
        chk("wrap_second", 32'(bus.s_axis_tready_o), 32'b1000);
        chk("wrap_tid0", 32'(bus.m_axis_tid_o), 32'd0);
        step();
        set_src(3, 1'b0, 8'h00);
        #1;
        chk("wrap_tid3", 32'(bus.m_axis_tid_o), 32'd3);
        chk("wrap_data3", 32'(bus.m_axis_tdata_o), 32'h0C3);
        step();

        // Single source 2 (pointer at 3, so the search must wrap past 0 and 1).
        set_src(2, 1'b1, 8'hA5);
        #1;
        chk("single_tready", 32'(bus.s_axis_tready_o), 32'b0100);
        chk("single_idle", 32'(bus.m_axis_tvalid_o), 32'd0);
        step();
        set_src(2, 1'b0, 8'h00);
        #1;
        chk("single_tvalid", 32'(bus.m_axis_tvalid_o), 32'd1);
        chk("single_tdata", 32'(bus.m_axis_tdata_o), 32'h0A5);
        chk("single_tid", 32'(bus.m_axis_tid_o), 32'd2);
        chk("single_no_repeat", 32'(bus.s_axis_tready_o), 32'd0);
        step();
        #1;
        chk("single_done", 32'(bus.m_axis_tvalid_o), 32'd0);

        // Backpressure: beat from source 1 held while source 0 waits.
        bus.m_axis_tready_i = 1'b0;
        set_src(1, 1'b1, 8'h3C);
        #1;
        chk("bp_grant", 32'(bus.s_axis_tready_o), 32'b0010);
        step();
        set_src(1, 1'b0, 8'h00);
        set_src(0, 1'b1, 8'h77);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_tvalid", 32'(bus.m_axis_tvalid_o), 32'd1);
            chk("bp_tdata", 32'(bus.m_axis_tdata_o), 32'h03C);
            chk("bp_tid", 32'(bus.m_axis_tid_o), 32'd1);
            chk("bp_tready", 32'(bus.s_axis_tready_o), 32'd0);
            step();
        end
        bus.m_axis_tready_i = 1'b1;
        #1;
        chk("bp_release_grant", 32'(bus.s_axis_tready_o), 32'b0001);
        step();
        set_src(0, 1'b0, 8'h00);
        #1;
        chk("bp_next_tid", 32'(bus.m_axis_tid_o), 32'd0);
        chk("bp_next_data", 32'(bus.m_axis_tdata_o), 32'h077);
        step();
        #1;
        chk("bp_idle", 32'(bus.m_axis_tvalid_o), 32'd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Random traffic; each source streams an incrementing sequence tagged with its index.
        vld = '0;
        for (int i = 0; i < NUM_SRC; i++) seq[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hs_last[i]) begin
                    seq[i]++;
                    vld[i] = ($urandom_range(0, 1) == 1);
                end else if (vld[i]) begin
                    if ($urandom_range(0, 9) == 0) vld[i] = 1'b0;
                end else begin
                    vld[i] = ($urandom_range(0, 1) == 1);
                end
                set_src(i, vld[i], {2'(i), seq[i]});
            end
            bus.m_axis_tready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.s_axis_tvalid_i = '0;
        bus.m_axis_tready_i = 1'b1;
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            step();
            budget++;
        end
        chk("rand_drain", 32'(sb.size()), 32'd0);
        step();
        #1;
        chk("rand_idle", 32'(bus.m_axis_tvalid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
